// File: rtl/tmds_word_aligner.sv
// Receive-side TMDS word aligner: slides a 10-bit window across two consecutive
// deserializer words until a run of control tokens marks the symbol boundary.
module tmds_word_aligner #(
  parameter int TOKEN_COUNT  = 8,
  parameter int SEARCH_DWELL = 1024,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_data,
  output logic [9:0] o_data,
  output logic       o_token,
  output logic       o_locked,
  output logic [3:0] o_offset
);

  localparam int TOK_W  = (TOKEN_COUNT  > 1) ? $clog2(TOKEN_COUNT)  : 1;
  localparam int DWL_W  = (SEARCH_DWELL > 1) ? $clog2(SEARCH_DWELL) : 1;
  localparam int LOSS_W = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;

  localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(TOKEN_COUNT - 1);
  localparam logic [DWL_W-1:0]  DWL_LAST  = DWL_W'(SEARCH_DWELL - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);
  localparam logic [TOK_W-1:0]  TOK_MAX   = {TOK_W{1'b1}};
  localparam logic [DWL_W-1:0]  DWL_MAX   = {DWL_W{1'b1}};
  localparam logic [LOSS_W-1:0] LOSS_MAX  = {LOSS_W{1'b1}};

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic logic token_match(input logic [9:0] w);
    logic m;
    case (w)
      10'b1101010100,
      10'b0010101011,
      10'b0101010100,
      10'b1010101011: m = 1'b1;
      default:        m = 1'b0;
    endcase
    return m;
  endfunction

  // Bit 19 of the full 20-bit stream is never inside any window, so it is not carried.
  function automatic logic [9:0] window_at(input logic [18:0] s, input logic [3:0] k);
    logic [9:0] w;
    case (k)
      4'd0:    w = s[9:0];
      4'd1:    w = s[10:1];
      4'd2:    w = s[11:2];
      4'd3:    w = s[12:3];
      4'd4:    w = s[13:4];
      4'd5:    w = s[14:5];
      4'd6:    w = s[15:6];
      4'd7:    w = s[16:7];
      4'd8:    w = s[17:8];
      4'd9:    w = s[18:9];
      default: w = s[9:0];
    endcase
    return w;
  endfunction

  state_e             state_q,  state_d;
  logic [9:0]         prev_q,   prev_d;
  logic [9:0]         data_q,   data_d;
  logic               token_q,  token_d;
  logic [3:0]         offset_q, offset_d;
  logic [TOK_W-1:0]   tok_q,    tok_d;
  logic [DWL_W-1:0]   dwell_q,  dwell_d;
  logic [LOSS_W-1:0]  loss_q,   loss_d;

  logic [18:0] stream_s;
  logic [9:0]  window_s;
  logic        win_tok_s;

  assign stream_s  = {i_data[8:0], prev_q};
  assign window_s  = window_at(stream_s, offset_q);
  assign win_tok_s = token_match(window_s);

  // Next-state logic for the search/lock machine and the aligned output word.
  always_comb begin
    prev_d   = i_data;
    data_d   = window_s;
    token_d  = win_tok_s;
    state_d  = state_q;
    offset_d = offset_q;
    tok_d    = tok_q;
    dwell_d  = dwell_q;
    loss_d   = loss_q;
    case (state_q)
      ST_SEARCH: begin
        loss_d = '0;
        // A completed token run takes priority over moving to the next offset.
        if (win_tok_s && (tok_q == TOK_LAST)) begin
          state_d = ST_LOCKED;
          tok_d   = '0;
          dwell_d = '0;
        end else if (dwell_q == DWL_LAST) begin
          offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          tok_d    = '0;
          dwell_d  = '0;
        end else begin
          dwell_d = (dwell_q == DWL_MAX) ? DWL_MAX : dwell_q + 1'b1;
          tok_d   = win_tok_s ? ((tok_q == TOK_MAX) ? TOK_MAX : tok_q + 1'b1) : '0;
        end
      end
      ST_LOCKED: begin
        tok_d   = '0;
        dwell_d = '0;
        if (win_tok_s) begin
          loss_d = '0;
        end else if (loss_q == LOSS_LAST) begin
          state_d = ST_SEARCH;
          loss_d  = '0;
        end else begin
          loss_d = (loss_q == LOSS_MAX) ? LOSS_MAX : loss_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_SEARCH;
        offset_d = 4'd0;
        tok_d    = '0;
        dwell_d  = '0;
        loss_d   = '0;
      end
    endcase
  end

  // State and output registers; reset returns to search at offset 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_SEARCH;
      prev_q   <= 10'd0;
      data_q   <= 10'd0;
      token_q  <= 1'b0;
      offset_q <= 4'd0;
      tok_q    <= '0;
      dwell_q  <= '0;
      loss_q   <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      data_q   <= data_d;
      token_q  <= token_d;
      offset_q <= offset_d;
      tok_q    <= tok_d;
      dwell_q  <= dwell_d;
      loss_q   <= loss_d;
    end
  end

  assign o_data   = data_q;
  assign o_token  = token_q;
  assign o_locked = (state_q == ST_LOCKED);
  assign o_offset = offset_q;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Bench for tmds_word_aligner: serial bit-stream stimulus, directed timing checks
// and a cycle-by-cycle comparison against a behavioural reference model.
module tb_tmds_word_aligner;

  localparam int TC = 4;
  localparam int SD = 16;
  localparam int LT = 32;
  localparam logic [9:0] TOK0   = 10'b1101010100;
  localparam logic [9:0] NONTOK = 10'b0110100110;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] din;
  logic [9:0] dout;
  logic       dtok;
  logic       dlocked;
  logic [3:0] doff;

  logic [9:0] tok_tbl [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  int tests_run    = 0;
  int tests_failed = 0;

  logic [9:0] m_prev, m_data;
  bit         m_token, m_locked;
  int         m_off, m_dwell, m_tok, m_loss;

  bit bitq[$];
  int gen_mode = 0;

  always #5 clk = ~clk;

  tmds_word_aligner #(
    .TOKEN_COUNT (TC),
    .SEARCH_DWELL(SD),
    .LOSS_TIMEOUT(LT)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (din),
    .o_data  (dout),
    .o_token (dtok),
    .o_locked(dlocked),
    .o_offset(doff)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_token(input logic [9:0] w);
    bit t = 1'b0;
    foreach (tok_tbl[i]) if (tok_tbl[i] == w) t = 1'b1;
    return t;
  endfunction

  // Reference model: one call per clock edge with the inputs seen on that edge.
  task automatic model_step(input logic r, input logic [9:0] d);
    logic [19:0] s;
    logic [9:0]  w;
    bit          t;
    if (r) begin
      m_prev = 10'd0; m_data = 10'd0; m_token = 1'b0; m_locked = 1'b0;
      m_off = 0; m_dwell = 0; m_tok = 0; m_loss = 0;
    end else begin
      s = {d, m_prev};
      w = 10'((s >> m_off) & 20'h003FF);
      t = is_token(w);
      m_data  = w;
      m_token = t;
      if (!m_locked) begin
        if (t && m_tok == TC - 1) begin
          m_locked = 1'b1; m_dwell = 0; m_tok = 0; m_loss = 0;
        end else if (m_dwell == SD - 1) begin
          m_off = (m_off + 1) % 10; m_dwell = 0; m_tok = 0;
        end else begin
          m_dwell++;
          m_tok = t ? m_tok + 1 : 0;
        end
      end else begin
        if (t) m_loss = 0;
        else if (m_loss == LT - 1) begin
          m_locked = 1'b0; m_loss = 0; m_dwell = 0; m_tok = 0;
        end else m_loss++;
      end
      m_prev = d;
    end
  endtask

  task automatic step(input logic r, input logic [9:0] d);
    rst = r;
    din = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    check("data",   {22'd0, dout},    {22'd0, m_data});
    check("token",  {31'd0, dtok},    {31'd0, m_token});
    check("locked", {31'd0, dlocked}, {31'd0, m_locked});
    check("offset", {28'd0, doff},    32'(m_off));
  endtask

  task automatic push_sym(input logic [9:0] sym);
    for (int b = 0; b < 10; b++) bitq.push_back(sym[b]);
  endtask

  task automatic next_word(output logic [9:0] w);
    logic [9:0] sym;
    while (bitq.size() < 10) begin
      case (gen_mode)
        0:       sym = TOK0;
        1:       sym = NONTOK;
        2:       sym = tok_tbl[$urandom_range(0, 3)];
        default: sym = 10'($urandom);
      endcase
      push_sym(sym);
    end
    for (int b = 0; b < 10; b++) w[b] = bitq.pop_front();
  endtask

  task automatic run(input int n);
    logic [9:0] w;
    for (int i = 0; i < n; i++) begin
      next_word(w);
      step(1'b0, w);
    end
  endtask

  task automatic reset_cycle();
    logic [9:0] w;
    next_word(w);
    step(1'b1, w);
  endtask

  // Run until lock is seen, returning the step index (or -1 if the budget expires).
  task automatic wait_lock(input int budget, output int lock_at);
    logic [9:0] w;
    lock_at = -1;
    for (int i = 1; i <= budget && lock_at < 0; i++) begin
      next_word(w);
      step(1'b0, w);
      if (i == 16) check("acq_offset_16", {28'd0, doff}, 32'd1);
      if (dlocked === 1'b1) lock_at = i;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lock_at;
    int drop_at;
    logic [9:0] w;

    // Reset state
    rst = 1'b1;
    din = 10'd0;
    step(1'b1, 10'h3FF);
    check("rst_data",   {22'd0, dout},    32'd0);
    check("rst_locked", {31'd0, dlocked}, 32'd0);
    check("rst_offset", {28'd0, doff},    32'd0);

    // Aligned token stream: lock after four token windows, offset stays 0
    bitq.delete(); gen_mode = 0;
    reset_cycle();
    lock_at = -1;
    for (int i = 1; i <= 10; i++) begin
      next_word(w);
      step(1'b0, w);
      if (lock_at < 0 && dlocked === 1'b1) lock_at = i;
      if (i >= 5) check("s1_data", {22'd0, dout}, {22'd0, TOK0});
    end
    check("s1_lock_cycle", 32'(lock_at), 32'd5);
    check("s1_offset",     {28'd0, doff}, 32'd0);

    // 31 non-token windows then a token: lock must hold
    gen_mode = 1; run(31);
    gen_mode = 0; run(3);
    check("s3_still_locked", {31'd0, dlocked}, 32'd1);

    // 32 non-token windows: lock drops, offset kept
    gen_mode = 1;
    drop_at = -1;
    for (int i = 1; i <= 40 && drop_at < 0; i++) begin
      next_word(w);
      step(1'b0, w);
      if (dlocked === 1'b0) drop_at = i;
    end
    check("s4_drop_cycle", 32'(drop_at), 32'd33);
    check("s4_offset",     {28'd0, doff}, 32'd0);

    // Searching with no tokens: offset walks to 9 and wraps to 0
    for (int i = 1; i <= 160; i++) begin
      next_word(w);
      step(1'b0, w);
      if (i == 16)  check("s5_offset_1",  {28'd0, doff}, 32'd1);
      if (i == 159) check("s5_offset_9",  {28'd0, doff}, 32'd9);
      if (i == 160) check("s5_wrap_to_0", {28'd0, doff}, 32'd0);
    end

    // Fourth token coincides with dwell expiry: lock wins
    step(1'b1, 10'd0);
    for (int i = 1; i <= 11; i++) step(1'b0, 10'd0);
    for (int i = 12; i <= 15; i++) step(1'b0, TOK0);
    check("s5_pre_lock", {31'd0, dlocked}, 32'd0);
    step(1'b0, TOK0);
    check("s5_lock_at_expiry", {31'd0, dlocked}, 32'd1);
    check("s5_no_advance",     {28'd0, doff},    32'd0);

    // Stream delayed by 3 bits: lock at offset 3
    bitq.delete(); gen_mode = 0;
    for (int b = 0; b < 3; b++) bitq.push_back(1'b0);
    reset_cycle();
    wait_lock(80, lock_at);
    check("s2_lock_cycle", 32'(lock_at), 32'd52);
    check("s2_offset",     {28'd0, doff}, 32'd3);
    check("s2_data",       {22'd0, dout}, {22'd0, TOK0});
    run(5);

    // Reset while locked, then re-acquire with the same timing
    reset_cycle();
    check("s6_locked", {31'd0, dlocked}, 32'd0);
    check("s6_offset", {28'd0, doff},    32'd0);
    check("s6_data",   {22'd0, dout},    32'd0);
    check("s6_token",  {31'd0, dtok},    32'd0);
    wait_lock(80, lock_at);
    check("s6_relock_cycle", 32'(lock_at), 32'd52);
    check("s6_relock_offset", {28'd0, doff}, 32'd3);

    // Randomized phases and symbol mixes against the model
    for (int r = 0; r < 4; r++) begin
      bitq.delete();
      for (int b = 0; b < $urandom_range(0, 9); b++) bitq.push_back(1'($urandom));
      gen_mode = 2;
      reset_cycle();
      run(180);
      gen_mode = 3; run(50);
      gen_mode = 2; run(60);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
